comp_result_debounce: RTL and testbench

- Sits directly downstream of comparator_3bit; consumes its lt/eq/gt flags once per valid sample.
- Commits a debounced comparison state only after DEBOUNCE consecutive identical valid results, and pulses on each committed change.
- Keeps saturating per-result event counters and flags malformed (non-one-hot) flag combinations.

---
 rtl/comp_result_debounce_if.sv | 27 ++
 rtl/comp_result_debounce.sv | 126 ++++++++++++
 tb/tb_comp_result_debounce.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/comp_result_debounce_if.sv
// Sample/flag bundle between the comparator stage and the debounce block.
// The master drives samples and counter clear; the slave returns state, pulses and counts.
interface comp_result_debounce_if #(
    parameter int CNT_W = 8
);
    logic             valid_in;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             clr_cnt;
    logic [1:0]       state_out;
    logic             change;
    logic             err;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;

    modport master (
        output valid_in, lt, eq, gt, clr_cnt,
        input  state_out, change, err, lt_cnt, eq_cnt, gt_cnt
    );

    modport slave (
        input  valid_in, lt, eq, gt, clr_cnt,
        output state_out, change, err, lt_cnt, eq_cnt, gt_cnt
    );
endinterface

// File: rtl/comp_result_debounce.sv
// Debounces lt/eq/gt comparator flags into a committed state, pulses on every commit,
// flags malformed samples and keeps saturating per-result event counters.
module comp_result_debounce #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    comp_result_debounce_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LT   = 2'b01,
        ST_EQ   = 2'b10,
        ST_GT   = 2'b11
    } cmp_e;

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    cmp_e             state_q, state_d;
    cmp_e             cand_q, cand_d;
    logic [3:0]       run_q, run_d;
    logic             change_q, change_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;

    cmp_e             code;
    logic             well_formed;
    logic [3:0]       run_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        well_formed = 1'b1;
        code        = ST_IDLE;
        unique case ({bus.lt, bus.eq, bus.gt})
            3'b100:  code = ST_LT;
            3'b010:  code = ST_EQ;
            3'b001:  code = ST_GT;
            default: well_formed = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        run_d    = run_q;
        run_next = 4'd0;
        change_d = 1'b0;
        err_d    = 1'b0;
        lt_cnt_d = lt_cnt_q;
        eq_cnt_d = eq_cnt_q;
        gt_cnt_d = gt_cnt_q;

        if (bus.valid_in) begin
            if (!well_formed) begin
                err_d  = 1'b1;
                run_d  = 4'd0;
                cand_d = ST_IDLE;
            end else begin
                unique case (code)
                    ST_LT:   lt_cnt_d = sat_inc(lt_cnt_q);
                    ST_EQ:   eq_cnt_d = sat_inc(eq_cnt_q);
                    default: gt_cnt_d = sat_inc(gt_cnt_q);
                endcase

                // A sample matching the committed state abandons any pending run.
                if (code == state_q) begin
                    cand_d = ST_IDLE;
                    run_d  = 4'd0;
                end else begin
                    run_next = (code == cand_q) ? run_q + 4'd1 : 4'd1;
                    if (run_next == DEB) begin
                        state_d  = code;
                        change_d = 1'b1;
                        run_d    = 4'd0;
                        cand_d   = ST_IDLE;
                    end else begin
                        run_d  = run_next;
                        cand_d = code;
                    end
                end
            end
        end

        // Clear wins over a same-cycle increment, so that sample is not counted.
        if (bus.clr_cnt) begin
            lt_cnt_d = '0;
            eq_cnt_d = '0;
            gt_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cand_q   <= ST_IDLE;
            run_q    <= 4'd0;
            change_q <= 1'b0;
            err_q    <= 1'b0;
            lt_cnt_q <= '0;
            eq_cnt_q <= '0;
            gt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            change_q <= change_d;
            err_q    <= err_d;
            lt_cnt_q <= lt_cnt_d;
            eq_cnt_q <= eq_cnt_d;
            gt_cnt_q <= gt_cnt_d;
        end
    end

    assign bus.state_out = state_q;
    assign bus.change    = change_q;
    assign bus.err       = err_q;
    assign bus.lt_cnt    = lt_cnt_q;
    assign bus.eq_cnt    = eq_cnt_q;
    assign bus.gt_cnt    = gt_cnt_q;
endmodule

// File: tb/tb_comp_result_debounce.sv
// Directed plus randomized bench for comp_result_debounce against a queue-based reference model.
module tb_comp_result_debounce;
    localparam int DEB   = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Reference model: committed state, pulses, counters, and the list of
    // well-formed samples seen since the last event that breaks a run.
    int   m_state = 0;
    int   m_change = 0;
    int   m_err = 0;
    int   m_cnt [3] = '{0, 0, 0};
    int   hist [$];

    comp_result_debounce_if #(.CNT_W(CW)) bus ();

    comp_result_debounce #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [2:0] c);
        case (c)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 0;
        endcase
    endfunction

    task automatic model(input logic r, input logic v, input logic [2:0] c, input logic clr);
        int s;
        int trail;
        if (r) begin
            m_state = 0; m_change = 0; m_err = 0;
            m_cnt = '{0, 0, 0};
            hist.delete();
            return;
        end
        m_change = 0;
        m_err    = 0;
        if (v) begin
            s = decode(c);
            if (s == 0) begin
                m_err = 1;
                hist.delete();
            end else begin
                if (m_cnt[s-1] < CMAX) m_cnt[s-1]++;
                if (s == m_state) begin
                    hist.delete();
                end else begin
                    hist.push_back(s);
                    trail = 0;
                    for (int i = hist.size() - 1; i >= 0; i--) begin
                        if (hist[i] != s) break;
                        trail++;
                    end
                    if (trail == DEB) begin
                        m_state  = s;
                        m_change = 1;
                        hist.delete();
                    end
                end
            end
        end
        if (clr) m_cnt = '{0, 0, 0};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("state_out", 32'(bus.state_out), m_state);
        chk("change",    32'(bus.change),    m_change);
        chk("err",       32'(bus.err),       m_err);
        chk("lt_cnt",    32'(bus.lt_cnt),    m_cnt[0]);
        chk("eq_cnt",    32'(bus.eq_cnt),    m_cnt[1]);
        chk("gt_cnt",    32'(bus.gt_cnt),    m_cnt[2]);
        chk("change_err_excl", 32'(bus.change & bus.err), 0);
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] c, input logic clr);
        @(negedge clk);
        rst          = r;
        bus.valid_in = v;
        {bus.lt, bus.eq, bus.gt} = c;
        bus.clr_cnt  = clr;
        @(posedge clk);
        model(r, v, c, clr);
        #1;
        chk_all();
    endtask

    initial begin
        logic [2:0] rc;
        logic       rv;
        logic       rclr;
        logic       rr;
        bus.valid_in = 1'b0;
        bus.lt = 1'b0; bus.eq = 1'b0; bus.gt = 1'b0;
        bus.clr_cnt = 1'b0;

        // Reset held two cycles with a GT sample presented.
        step(1, 1, 3'b001, 0);
        step(1, 1, 3'b001, 0);
        chk("reset_state", 32'(bus.state_out), 0);
        chk("reset_gt_cnt", 32'(bus.gt_cnt), 0);

        // Commit after three GT samples; change lasts one cycle.
        step(0, 1, 3'b001, 0);
        step(0, 1, 3'b001, 0);
        chk("commit_not_yet", 32'(bus.state_out), 0);
        step(0, 1, 3'b001, 0);
        chk("commit_state", 32'(bus.state_out), 2'b11);
        chk("commit_change", 32'(bus.change), 1);
        chk("commit_gt_cnt", 32'(bus.gt_cnt), 3);
        step(0, 0, 3'b000, 0);
        chk("commit_change_drop", 32'(bus.change), 0);

        // Interrupted run never commits.
        step(1, 0, 3'b000, 0);
        step(0, 1, 3'b001, 0);
        step(0, 1, 3'b001, 0);
        step(0, 1, 3'b100, 0);
        step(0, 1, 3'b001, 0);
        step(0, 1, 3'b001, 0);
        chk("intr_state", 32'(bus.state_out), 0);
        chk("intr_gt_cnt", 32'(bus.gt_cnt), 4);
        chk("intr_lt_cnt", 32'(bus.lt_cnt), 1);
        step(0, 1, 3'b001, 0);
        chk("intr_commit", 32'(bus.state_out), 2'b11);

        // Malformed samples, then a run split by idle cycles.
        step(0, 1, 3'b110, 0);
        chk("malformed_err", 32'(bus.err), 1);
        chk("malformed_gt_cnt", 32'(bus.gt_cnt), 5);
        step(0, 1, 3'b111, 0);
        step(0, 1, 3'b000, 0);
        step(0, 1, 3'b010, 0);
        chk("gap_err_drop", 32'(bus.err), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 3'b010, 0);
        step(0, 1, 3'b010, 0);
        step(0, 1, 3'b010, 0);
        chk("gap_commit", 32'(bus.state_out), 2'b10);

        // Saturation and clear priority.
        for (int i = 0; i < 20; i++) step(0, 1, 3'b010, 0);
        chk("sat_eq_cnt", 32'(bus.eq_cnt), CMAX);
        step(0, 1, 3'b010, 1);
        chk("clr_eq_cnt", 32'(bus.eq_cnt), 0);

        // Reset discards a partial run.
        step(1, 0, 3'b000, 0);
        step(0, 1, 3'b100, 0);
        step(0, 1, 3'b100, 0);
        step(1, 0, 3'b000, 0);
        step(0, 1, 3'b100, 0);
        chk("midrst_state", 32'(bus.state_out), 0);
        step(0, 1, 3'b100, 0);
        step(0, 1, 3'b100, 0);
        chk("midrst_commit", 32'(bus.state_out), 2'b01);
        chk("midrst_change", 32'(bus.change), 1);

        // Randomized traffic biased toward runs of the same code.
        rc = 3'b100;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0:       rc = 3'($urandom_range(0, 7));
                    1, 2, 3: rc = 3'b100;
                    4, 5, 6: rc = 3'b010;
                    default: rc = 3'b001;
                endcase
            end
            rv   = ($urandom_range(0, 4) != 0);
            rclr = ($urandom_range(0, 40) == 0);
            rr   = ($urandom_range(0, 120) == 0);
            step(rr, rv, rc, rclr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
